ps2_tx: RTL

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_tx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 byte transmitter driving open-drain line enables.
// Optional watchdog on the device-clocked phase: define PS2_TX_TIMEOUT_EN.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbClk,
  input  logic       kbData,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       kbClk_low,
  output logic       kbData_low,
  output logic       done,
  output logic       err
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST   = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PENULT = IW'(INHIBIT_CYCLES - 2);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic kb_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= kbClk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= kbData;
      data_s2_q  <= data_s1_q;
    end
  end

  assign kb_fall = clk_prev_q & ~clk_s2_q;

  state_t          state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            parity_q, parity_d;
  logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            tx_ready_q, tx_ready_d;
  logic            clk_low_q, clk_low_d;
  logic            data_low_q, data_low_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    parity_d   = parity_q;
    inh_cnt_d  = inh_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_ready_d = tx_ready_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          byte_d     = tx_data;
          parity_d   = ~^tx_data;
          inh_cnt_d  = '0;
          clk_low_d  = 1'b1;
          data_low_d = (INHIBIT_CYCLES == 1);
          tx_ready_d = 1'b0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + IW'(1);
        // Start bit goes on the line one cycle before the clock is released.
        if (inh_cnt_q == INH_PENULT) begin
          data_low_d = 1'b1;
        end
        if (inh_cnt_q == INH_LAST) begin
          clk_low_d = 1'b0;
          state_d   = START;
`ifdef PS2_TX_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
        end
      end
      START: begin
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (kb_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            data_low_d = ~byte_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_low_d = ~parity_q;
          end else begin
            data_low_d = 1'b0;
            state_d    = ACK;
          end
        end
      end
      ACK: begin
        if (kb_fall) begin
          if (data_s2_q) begin
            err_d      = 1'b1;
            tx_ready_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_s2_q && data_s2_q) begin
          done_d     = 1'b1;
          tx_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        tx_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog wins over every other transition, which also keeps done and err exclusive.
    if (state_q == START || state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) begin
      to_cnt_d = to_cnt_q + TW'(1);
      if (to_cnt_q == TO_LAST) begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b1;
        tx_ready_d = 1'b1;
        state_d    = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_q     <= '0;
      parity_q   <= 1'b0;
      inh_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_ready_q <= 1'b1;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      inh_cnt_q  <= inh_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_ready_q <= tx_ready_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign tx_ready   = tx_ready_q;
  assign kbClk_low  = clk_low_q;
  assign kbData_low = data_low_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
